// File: rtl/shreg_univ_pkg.sv
// rtl/shreg_univ_pkg.sv - mode codes shared by the shift register and the FSMs that drive it
package shreg_univ_pkg;

    localparam int SHREG_MODE_W = 3;

    typedef enum logic [SHREG_MODE_W-1:0] {
        SHREG_HOLD = 3'd0,
        SHREG_SHL  = 3'd1,
        SHREG_SHR  = 3'd2,
        SHREG_ROTL = 3'd3,
        SHREG_ROTR = 3'd4,
        SHREG_LOAD = 3'd5
    } shreg_mode_e;

    function automatic logic shreg_is_shift(input logic [SHREG_MODE_W-1:0] m);
        return (m == SHREG_SHL) || (m == SHREG_SHR) ||
               (m == SHREG_ROTL) || (m == SHREG_ROTR);
    endfunction

endpackage

// File: rtl/shreg_cnt.sv
// rtl/shreg_cnt.sv - saturating shift counter with registered done flag
module shreg_cnt #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (inc && (cnt != CW'(MAX)))
            cnt_nxt = cnt + 1'b1;
    end

    // done tracks the next count so it rises on the same edge as the final shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            done <= (cnt_nxt == CW'(MAX));
        end
    end

endmodule

// File: rtl/shreg_univ.sv
// rtl/shreg_univ.sv - universal shift register: hold/shift/rotate/load, sync clear/preset, shift count
module shreg_univ
    import shreg_univ_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    pst,
    input  logic [SHREG_MODE_W-1:0] mode,
    input  logic                    sil,
    input  logic                    sir,
    input  logic [WIDTH-1:0]        d,
    output logic [WIDTH-1:0]        q,
    output logic                    so_msb,
    output logic                    so_lsb,
    output logic                    done
);

    logic [WIDTH-1:0] q_nxt;
    logic             cnt_clr;
    logic             cnt_inc;

    // shift-operator forms stay legal for WIDTH==1, where rotates collapse to hold
    always_comb begin
        q_nxt = q;
        if (clr)
            q_nxt = '0;
        else if (pst)
            q_nxt = PRESET_VAL;
        else begin
            case (shreg_mode_e'(mode))
                SHREG_SHL:  q_nxt = (q << 1) | WIDTH'(sil);
                SHREG_SHR:  q_nxt = (q >> 1) | (WIDTH'(sir) << (WIDTH - 1));
                SHREG_ROTL: q_nxt = (q << 1) | WIDTH'(q[WIDTH-1]);
                SHREG_ROTR: q_nxt = (q >> 1) | (WIDTH'(q[0]) << (WIDTH - 1));
                SHREG_LOAD: q_nxt = d;
                default:    q_nxt = q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= RESET_VAL;
        else
            q <= q_nxt;
    end

    assign cnt_clr = clr || pst || (mode == SHREG_LOAD);
    assign cnt_inc = shreg_is_shift(mode);

    shreg_cnt #(.MAX(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .done (done)
    );

    assign so_msb = q[WIDTH-1];
    assign so_lsb = q[0];

endmodule

// File: tb/tb_shreg_univ.sv
// tb/tb_shreg_univ.sv - randomized and directed checks of shreg_univ against a behavioural model
module tb_shreg_univ;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       clr  = 1'b0;
    logic       pst  = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       sil  = 1'b0;
    logic       sir  = 1'b0;
    logic [7:0] d    = 8'h00;
    logic [7:0] q;
    logic       so_msb;
    logic       so_lsb;
    logic       done;

    int checks = 0;
    int errors = 0;
    int m_q    = 0;
    int m_cnt  = 0;

    shreg_univ #(.WIDTH(8), .RESET_VAL(8'h00), .PRESET_VAL(8'hFF)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .pst    (pst),
        .mode   (mode),
        .sil    (sil),
        .sir    (sir),
        .d      (d),
        .q      (q),
        .so_msb (so_msb),
        .so_lsb (so_lsb),
        .done   (done)
    );

    always #5 clk = ~clk;

    // behavioural reference: q as an integer 0..255, shifts as arithmetic
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q   = 0;
            m_cnt = 0;
        end else if (clr) begin
            m_q   = 0;
            m_cnt = 0;
        end else if (pst) begin
            m_q   = 255;
            m_cnt = 0;
        end else begin
            case (mode)
                3'd1: m_q = (m_q * 2) % 256 + int'(sil);
                3'd2: m_q = m_q / 2 + int'(sir) * 128;
                3'd3: m_q = (m_q * 2) % 256 + m_q / 128;
                3'd4: m_q = m_q / 2 + (m_q % 2) * 128;
                3'd5: m_q = int'(d);
                default: ;
            endcase
            if (mode == 3'd5)
                m_cnt = 0;
            else if (mode >= 3'd1 && mode <= 3'd4 && m_cnt < 8)
                m_cnt = m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("model_q", 32'(q), 32'(m_q));
            chk("model_so_msb", 32'(so_msb), 32'(m_q / 128));
            chk("model_so_lsb", 32'(so_lsb), 32'(m_q % 2));
            chk("model_done", 32'(done), 32'(m_cnt == 8));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic l, input logic r, input logic [7:0] dd,
                      input logic c, input logic p);
        mode = m; sil = l; sir = r; d = dd; clr = c; pst = p;
        tick();
    endtask

    logic [7:0] t1_q   [8] = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    logic       t1_msb [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] t3_q   [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    initial begin
        #2;
        chk("reset_q", 32'(q), 32'h00);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_so", 32'({so_msb, so_lsb}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: serialise A5 out of the MSB
        op(3'd5, 0, 0, 8'hA5, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("t1_so_msb", 32'(so_msb), 32'(t1_msb[i]));
            chk("t1_done_pre", 32'(done), 32'd0);
            op(3'd1, 0, 0, 8'h00, 0, 0);
            chk("t1_q", 32'(q), 32'(t1_q[i]));
        end
        chk("t1_done", 32'(done), 32'd1);

        // 2: rotates keep every bit
        op(3'd5, 0, 0, 8'h81, 0, 0);
        op(3'd4, 0, 0, 8'h00, 0, 0);
        chk("t2_rotr", 32'(q), 32'hC0);
        op(3'd3, 0, 0, 8'h00, 0, 0);
        op(3'd3, 0, 0, 8'h00, 0, 0);
        chk("t2_rotl", 32'(q), 32'h03);
        chk("t2_done", 32'(done), 32'd0);

        // 3: fill with ones from the top, then one extra shift
        op(3'd0, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 8; i++) begin
            op(3'd2, 0, 1, 8'h00, 0, 0);
            chk("t3_q", 32'(q), 32'(t3_q[i]));
        end
        chk("t3_done", 32'(done), 32'd1);
        op(3'd2, 0, 1, 8'h00, 0, 0);
        chk("t3_q9", 32'(q), 32'hFF);
        chk("t3_done9", 32'(done), 32'd1);

        // 4: clear beats preset beats load
        op(3'd5, 0, 0, 8'h5A, 1, 1);
        chk("t4_clr_q", 32'(q), 32'h00);
        chk("t4_clr_done", 32'(done), 32'd0);
        op(3'd0, 0, 0, 8'h00, 0, 1);
        chk("t4_pst_q", 32'(q), 32'hFF);

        // 5: async reset mid-period during a shift sequence
        op(3'd0, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) op(3'd1, 1, 0, 8'h00, 0, 0);
        chk("t5_pre", 32'(q), 32'h0F);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_q", 32'(q), 32'h00);
        chk("t5_async_done", 32'(done), 32'd0);
        rst = 1'b1;
        op(3'd0, 0, 0, 8'h00, 0, 0);
        chk("t5_hold", 32'(q), 32'h00);

        // 6: reserved codes hold and do not count
        op(3'd5, 0, 0, 8'h3C, 0, 0);
        op(3'd6, 1, 1, 8'hFF, 0, 0);
        op(3'd7, 1, 1, 8'hFF, 0, 0);
        op(3'd6, 1, 1, 8'hFF, 0, 0);
        chk("t6_q", 32'(q), 32'h3C);
        chk("t6_done", 32'(done), 32'd0);
        for (int i = 0; i < 7; i++) op(3'd3, 0, 0, 8'h00, 0, 0);
        chk("t6_done7", 32'(done), 32'd0);
        op(3'd3, 0, 0, 8'h00, 0, 0);
        chk("t6_q8", 32'(q), 32'h3C);
        chk("t6_done8", 32'(done), 32'd1);

        // random traffic, shift-heavy so done is reached regularly
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r < 11)      mode = 3'(1 + (r % 4));
            else if (r < 12) mode = 3'd5;
            else if (r < 14) mode = 3'd0;
            else             mode = 3'(6 + (r % 2));
            sil = 1'($urandom);
            sir = 1'($urandom);
            d   = 8'($urandom);
            clr = ($urandom_range(0, 39) == 0);
            pst = ($urandom_range(0, 39) == 0);
            tick();
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                #1;
                chk("rand_async_q", 32'(q), 32'h00);
                chk("rand_async_done", 32'(done), 32'd0);
                rst = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
